fifo_buffer: RTL
================

FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 2, SHALL set the pointer width, giving DEPTH = 2**ADDR_WIDTH entries (4 by default).
REQ-003 Parameter AF_THRESH, default 3, SHALL set the almost-full level.
REQ-004 Parameter AE_THRESH, default 1, SHALL set the almost-empty level.
REQ-005 One clock and asynchronous active-high reset SHALL be used: clk (input, 1, rising-edge clock) and reset (input, 1, asynchronous active-high reset).
REQ-006 Port push SHALL be an input, 1 bit: write request.
REQ-007 Port data_in SHALL be an input, DATA_WIDTH bits: write data.
REQ-008 Port pop SHALL be an input, 1 bit: read request.
REQ-009 Port data_out SHALL be an output, DATA_WIDTH bits, registered: read data, intended to feed one 8-bit input channel of the downstream 2:1 mux.
REQ-010 Port valid_out SHALL be an output, 1 bit, registered: data_out qualifier, intended to feed the matching mux valid input.
REQ-011 Port full SHALL be an output, 1 bit, combinational from count: count == DEPTH.
REQ-012 Port empty SHALL be an output, 1 bit, combinational from count: count == 0.
REQ-013 Port almost_full SHALL be an output, 1 bit: count >= AF_THRESH.
REQ-014 Port almost_empty SHALL be an output, 1 bit: count <= AE_THRESH.
REQ-015 Port error_out SHALL be an output, 1 bit: sticky overflow/underflow flag.

Function
REQ-016 Storage SHALL be DEPTH x DATA_WIDTH registers, with a write pointer, a read pointer (ADDR_WIDTH bits each, wrap modulo DEPTH) and an occupancy count (ADDR_WIDTH+1 bits).
REQ-017 push with !full SHALL, at the clk edge, write data_in at the write pointer and increment the write pointer.
REQ-018 pop with !empty SHALL, at the clk edge, load data_out from the read pointer, set valid_out=1 and increment the read pointer; read latency is 1 cycle.
REQ-019 In any cycle without an accepted pop, valid_out SHALL be 0 and data_out SHALL hold its previous value.
REQ-020 Count SHALL change as follows: +1 for accepted push only, -1 for accepted pop only, unchanged for both or neither.
REQ-021 push and pop in the same cycle when full SHALL both be accepted (pop frees the slot); count remains DEPTH.
REQ-022 push and pop in the same cycle when empty SHALL accept only the push (no bypass); valid_out=0, and count becomes 1.
REQ-023 push while full without pop (overflow) SHALL drop data_in, leave pointers and count unchanged, and set error_out.
REQ-024 pop while empty (underflow) SHALL leave pointers and count unchanged, drive valid_out=0, and set error_out.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order SHALL be strict FIFO across wraps.
REQ-026 Flags SHALL reflect the count after each clk edge with no extra cycle of lag.

Reset
REQ-027 Asserting reset SHALL immediately clear the pointers, count, data_out (0), valid_out (0) and error_out (0), giving empty=1, almost_empty=1, full=0, almost_full=0.
REQ-028 Storage contents SHALL NOT be reset; reset mid-operation discards all queued data, and push/pop SHALL be honoured from the first clk edge after deassertion.

Configuration
REQ-029 With macro FIFO_ERROR_FLAG_EN defined, error_out SHALL behave per REQ-023/REQ-024 and SHALL remain 1 until reset.
REQ-030 Without FIFO_ERROR_FLAG_EN, error_out SHALL be tied to 0 and no error register SHALL be inferred; drop/ignore behaviour of overflow/underflow SHALL be unchanged.

Verification
REQ-031 Reset, then push 0xA1,0xB2,0xC3,0xD4 on consecutive cycles -> full=1, almost_full=1 after the 3rd push, empty=0.
REQ-032 From full, pop 4 cycles -> data_out 0xA1,0xB2,0xC3,0xD4 each one cycle after its pop with valid_out=1, then empty=1.
REQ-033 Full, push 0xEE without pop -> data dropped, count stays 4, error_out=1 (0 without FIFO_ERROR_FLAG_EN), subsequent pops return the original 4 words.
REQ-034 Full, push 0x55 with pop in the same cycle -> data_out=head word, count 4; after wrap, 0x55 emerges last in order.
REQ-035 Empty, push 0x33 with pop in the same cycle -> valid_out=0, count 1; next pop -> data_out=0x33, valid_out=1.
REQ-036 With 2 entries queued, assert reset between clk edges -> outputs clear asynchronously, empty=1; pop after release -> valid_out=0 and error_out=1 (underflow).

Source files
------------

// File: rtl/fifo_buffer.sv
// Synchronous FIFO with registered read port, occupancy flags and an optional sticky error flag.
// Define FIFO_ERROR_FLAG_EN to build the overflow/underflow error register; otherwise error_out is 0.
module fifo_buffer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned AF_THRESH  = 3,
   parameter int unsigned AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  error_out
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AfCnt    = (ADDR_WIDTH + 1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AeCnt    = (ADDR_WIDTH + 1)'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_out_q, valid_out_d;
   logic                  push_ok, pop_ok;

   assign full         = (count_q == DepthCnt);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AfCnt);
   assign almost_empty = (count_q <= AeCnt);

   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      if (push_ok) begin
         wr_ptr_d = ADDR_WIDTH'(wr_ptr_q + 1'b1);
      end
      if (pop_ok) begin
         rd_ptr_d    = ADDR_WIDTH'(rd_ptr_q + 1'b1);
         data_out_d  = mem_q[rd_ptr_q];
         valid_out_d = 1'b1;
      end
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

`ifdef FIFO_ERROR_FLAG_EN
   logic error_q, error_d;

   always_comb begin
      error_d = error_q;
      if ((push && full && !pop) || (pop && empty)) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error_out = error_q;
`else
   assign error_out = 1'b0;
`endif

endmodule
